night_cycle_controller: RTL and testbench

//   Sequences the day/night colour scheme at run time.

---
 rtl/night_cycle_pkg.sv | 15 +
 rtl/night_cycle_controller_stepper.sv | 25 ++
 rtl/night_cycle_controller.sv | 146 ++++++++++++++
 tb/tb_night_cycle_controller.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/night_cycle_pkg.sv
// Shared types and constants for the day/night colour sequencer.
// Optional moon phase counter is enabled by NIGHT_CYCLE_MOON_EN.
package night_cycle_pkg;

  typedef enum logic [1:0] {
    DAY,
    FADE_IN,
    NIGHT,
    FADE_OUT
  } night_state_t;

  localparam int NIGHT_RATE_W = 8;
  localparam int MOON_PHASES  = 7;

endpackage

// File: rtl/night_cycle_controller_stepper.sv
// Saturating one-frame step of the night rate, up toward max or down to 0.
// Purely combinational; the 9-bit sum keeps the up-step from wrapping.
module night_rate_stepper
  import night_cycle_pkg::*;
(
  input  logic [NIGHT_RATE_W-1:0] rate,
  input  logic [NIGHT_RATE_W-1:0] step,
  input  logic [NIGHT_RATE_W-1:0] max_rate,
  input  logic                    dir_up,
  output logic [NIGHT_RATE_W-1:0] next_rate
);

  logic [NIGHT_RATE_W:0] sum;

  always_comb begin
    sum = {1'b0, rate} + {1'b0, step};
    if (dir_up) begin
      next_rate = (sum > {1'b0, max_rate}) ? max_rate
                                           : sum[NIGHT_RATE_W-1:0];
    end else begin
      next_rate = (rate <= step) ? '0 : rate - step;
    end
  end

endmodule

// File: rtl/night_cycle_controller.sv
// Day/night sequencer driving the palette night_rate once per frame.
// Define NIGHT_CYCLE_MOON_EN to add the moon_phase output and register.
module night_cycle_controller
  import night_cycle_pkg::*;
#(
  parameter int MAX_NIGHT_RATE    = 255,
  parameter int FADE_STEP         = 5,
  parameter int NIGHT_HOLD_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       run,
  input  logic       restart,
  input  logic       trigger,
  output logic [7:0] night_rate,
  output logic       is_night,
  output logic       fading
`ifdef NIGHT_CYCLE_MOON_EN
  ,
  output logic [2:0] moon_phase
`endif
);

  localparam int HOLD_W = $clog2(NIGHT_HOLD_FRAMES + 1);

  localparam logic [NIGHT_RATE_W-1:0] MAX_R =
    NIGHT_RATE_W'(MAX_NIGHT_RATE);
  localparam logic [NIGHT_RATE_W-1:0] STEP_R =
    NIGHT_RATE_W'(FADE_STEP);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(NIGHT_HOLD_FRAMES - 1);

  night_state_t            state_d, state_q;
  logic [NIGHT_RATE_W-1:0] rate_d, rate_q;
  logic [HOLD_W-1:0]       hold_d, hold_q;
  logic                    pending_d, pending_q;
  logic                    is_night_d, is_night_q;
  logic                    fading_d, fading_q;
  logic [NIGHT_RATE_W-1:0] rate_step;
  logic                    step_up;
  logic                    advance;

  assign step_up = (state_q != FADE_OUT);
  assign advance = run && frame_start;

  night_rate_stepper u_stepper (
    .rate      (rate_q),
    .step      (STEP_R),
    .max_rate  (MAX_R),
    .dir_up    (step_up),
    .next_rate (rate_step)
  );

  always_comb begin
    state_d   = state_q;
    rate_d    = rate_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    if (restart) begin
      state_d   = DAY;
      rate_d    = '0;
      hold_d    = '0;
      pending_d = 1'b0;
    end else if (run) begin
      unique case (state_q)
        DAY: begin
          if (trigger) pending_d = 1'b1;
          if (frame_start && (pending_q || trigger)) begin
            state_d   = FADE_IN;
            rate_d    = rate_step;
            pending_d = 1'b0;
          end
        end
        FADE_IN: begin
          if (advance) begin
            rate_d = rate_step;
            if (rate_step == MAX_R) begin
              state_d = NIGHT;
              hold_d  = '0;
            end
          end
        end
        NIGHT: begin
          if (advance) begin
            hold_d = hold_q + 1'b1;
            if (hold_q == HOLD_LAST) state_d = FADE_OUT;
          end
        end
        FADE_OUT: begin
          if (advance) begin
            rate_d = rate_step;
            if (rate_step == '0) state_d = DAY;
          end
        end
      endcase
    end
    is_night_d = (state_d == NIGHT);
    fading_d   = (state_d == FADE_IN) || (state_d == FADE_OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= DAY;
      rate_q     <= '0;
      hold_q     <= '0;
      pending_q  <= 1'b0;
      is_night_q <= 1'b0;
      fading_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      rate_q     <= rate_d;
      hold_q     <= hold_d;
      pending_q  <= pending_d;
      is_night_q <= is_night_d;
      fading_q   <= fading_d;
    end
  end

  assign night_rate = rate_q;
  assign is_night   = is_night_q;
  assign fading     = fading_q;

`ifdef NIGHT_CYCLE_MOON_EN
  logic       enter_night;
  logic [2:0] moon_d, moon_q;

  assign enter_night = (state_q == FADE_IN) && (state_d == NIGHT);

  // restart deliberately leaves the phase alone
  always_comb begin
    moon_d = moon_q;
    if (enter_night) begin
      moon_d = (moon_q == 3'(MOON_PHASES - 1)) ? '0 : moon_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) moon_q <= '0;
    else        moon_q <= moon_d;
  end

  assign moon_phase = moon_q;
`endif

endmodule

// File: tb/tb_night_cycle_controller.sv
// Scoreboard bench: two DUTs (step 51 and step 100) share stimulus and
// are compared every cycle against a frame-level reference model.
module tb_night_cycle_controller;

  localparam int MAXR = 255;
  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic run = 1'b1;
  logic restart = 1'b0;
  logic trigger = 1'b0;

  logic [7:0] rate_a, rate_b;
  logic       night_a, night_b;
  logic       fade_a, fade_b;
  logic [2:0] moon_a, moon_b;

  always #5 clk = ~clk;

  night_cycle_controller #(
    .MAX_NIGHT_RATE(MAXR), .FADE_STEP(51), .NIGHT_HOLD_FRAMES(HOLD)
  ) u_a (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run),
    .restart(restart), .trigger(trigger), .night_rate(rate_a),
    .is_night(night_a), .fading(fade_a)
`ifdef NIGHT_CYCLE_MOON_EN
    , .moon_phase(moon_a)
`endif
  );

  night_cycle_controller #(
    .MAX_NIGHT_RATE(MAXR), .FADE_STEP(100), .NIGHT_HOLD_FRAMES(HOLD)
  ) u_b (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .run(run),
    .restart(restart), .trigger(trigger), .night_rate(rate_b),
    .is_night(night_b), .fading(fade_b)
`ifdef NIGHT_CYCLE_MOON_EN
    , .moon_phase(moon_b)
`endif
  );

`ifndef NIGHT_CYCLE_MOON_EN
  assign moon_a = 3'd0;
  assign moon_b = 3'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp,
               $time);
    end
  endtask

  // Reference model: dir +1 fading in, -1 fading out, 0 idle;
  // hold_left counts remaining night frames (nonzero means night).
  int steps[2] = '{51, 100};
  int m_rate[2], m_dir[2], m_hold[2], m_pend[2], m_moon[2];
  logic [12:0] exp_a[$];
  logic [12:0] exp_b[$];

  task automatic model(input int i, input bit rst, input bit fs,
                       input bit rn, input bit rs, input bit tr);
    bit day;
    int moon_v;
    if (rst) begin
      m_rate[i] = 0; m_dir[i] = 0; m_hold[i] = 0;
      m_pend[i] = 0; m_moon[i] = 0;
    end else if (rs) begin
      m_rate[i] = 0; m_dir[i] = 0; m_hold[i] = 0; m_pend[i] = 0;
    end else if (rn) begin
      day = (m_dir[i] == 0) && (m_hold[i] == 0);
      if (day && tr) m_pend[i] = 1;
      if (fs) begin
        if (day) begin
          if (m_pend[i] != 0) begin
            m_pend[i] = 0;
            m_dir[i] = 1;
            m_rate[i] = (m_rate[i] + steps[i] > MAXR) ? MAXR
                                                      : m_rate[i] + steps[i];
          end
        end else if (m_dir[i] == 1) begin
          m_rate[i] = (m_rate[i] + steps[i] > MAXR) ? MAXR
                                                    : m_rate[i] + steps[i];
          if (m_rate[i] == MAXR) begin
            m_dir[i] = 0;
            m_hold[i] = HOLD;
            m_moon[i] = (m_moon[i] + 1) % 7;
          end
        end else if (m_dir[i] == -1) begin
          m_rate[i] = (m_rate[i] - steps[i] < 0) ? 0
                                                 : m_rate[i] - steps[i];
          if (m_rate[i] == 0) m_dir[i] = 0;
        end else begin
          m_hold[i]--;
          if (m_hold[i] == 0) m_dir[i] = -1;
        end
      end
    end
`ifdef NIGHT_CYCLE_MOON_EN
    moon_v = m_moon[i];
`else
    moon_v = 0;
`endif
    if (i == 0)
      exp_a.push_back({3'(moon_v), m_dir[i] != 0,
                       (m_dir[i] == 0) && (m_hold[i] > 0), 8'(m_rate[i])});
    else
      exp_b.push_back({3'(moon_v), m_dir[i] != 0,
                       (m_dir[i] == 0) && (m_hold[i] > 0), 8'(m_rate[i])});
  endtask

  always @(negedge clk) begin
    logic [12:0] e;
    if (exp_a.size() > 0) begin
      e = exp_a.pop_front();
      check("sb_a", int'({moon_a, fade_a, night_a, rate_a}), int'(e));
    end
    if (exp_b.size() > 0) begin
      e = exp_b.pop_front();
      check("sb_b", int'({moon_b, fade_b, night_b, rate_b}), int'(e));
    end
  end

  bit run_v = 1'b1;

  task automatic tick(input bit rst, input bit fs, input bit rs,
                      input bit tr);
    rst_n = !rst;
    frame_start = fs;
    run = run_v;
    restart = rs;
    trigger = tr;
    @(posedge clk);
    #1;
    model(0, rst, fs, run_v, rs, tr);
    model(1, rst, fs, run_v, rs, tr);
    frame_start = 1'b0;
    restart = 1'b0;
    trigger = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic frame(input bit tr_mid);
    tick(0, 1, 0, 0);
  endtask

  task automatic idle(input bit tr_mid);
    tick(0, 0, 0, tr_mid);
    tick(0, 0, 0, 0);
  endtask

  int tr_a[16] = '{51, 102, 153, 204, 255, 255, 255, 255,
                   255, 204, 153, 102, 51, 0, 0, 0};
  int tr_b[16] = '{100, 200, 255, 255, 255, 255, 255, 155,
                   55, 0, 0, 0, 0, 0, 0, 0};
  int ni_a[16] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
  int fd_a[16] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};

  initial begin
    // reset
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    check("rst_rate", int'(rate_a), 0);
    check("rst_night", int'(night_a), 0);
    check("rst_fade", int'(fade_a), 0);
    check("rst_moon", int'(moon_a), 0);

    // full cycle, trigger mid-frame; extra trigger while b is at night
    idle(1);
    for (int f = 0; f < 16; f++) begin
      frame(0);
      check("cyc_rate_a", int'(rate_a), tr_a[f]);
      check("cyc_rate_b", int'(rate_b), tr_b[f]);
      check("cyc_night_a", int'(night_a), ni_a[f]);
      check("cyc_fade_a", int'(fade_a), fd_a[f]);
      idle(f == 3);
    end

    // restart mid fade-in at rate 102
    idle(1);
    frame(0); idle(0);
    frame(0); idle(0);
    check("rs_pre", int'(rate_a), 102);
    tick(0, 0, 1, 0);
    check("rs_rate", int'(rate_a), 0);
    check("rs_fade", int'(fade_a), 0);
    frame(0); idle(0);
    check("rs_stay", int'(rate_a), 0);

    // pause in night with hold count 1
    idle(1);
    for (int f = 0; f < 6; f++) begin frame(0); idle(0); end
    run_v = 1'b0;
    for (int f = 0; f < 10; f++) begin
      frame(0); idle(1);
      check("pause_rate", int'(rate_a), 255);
    end
    run_v = 1'b1;
    frame(0); idle(0);
    frame(0); idle(0);
    check("resume_night", int'(night_a), 1);
    frame(0); idle(0);
    check("resume_fade", int'(fade_a), 1);
    check("resume_rate", int'(rate_a), 255);
    for (int f = 0; f < 8; f++) begin frame(0); idle(0); end
    check("back_day", int'(rate_a), 0);

`ifdef NIGHT_CYCLE_MOON_EN
    tick(1, 0, 0, 0);
    for (int c = 1; c <= 8; c++) begin
      idle(1);
      for (int f = 0; f < 15; f++) begin frame(0); idle(0); end
      check("moon", int'(moon_a), c % 7);
    end
    tick(0, 0, 1, 0);
    check("moon_rs", int'(moon_a), 1);
`endif

    // randomized traffic
    for (int k = 0; k < 4000; k++) begin
      run_v = ($urandom_range(0, 9) != 0);
      tick($urandom_range(0, 599) == 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 79) == 0,
           $urandom_range(0, 14) == 0);
    end
    run_v = 1'b1;
    tick(0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("sb_drain_a", exp_a.size(), 0);
    check("sb_drain_b", exp_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp,
             n_bad);
    $finish;
  end

endmodule
